keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Desc     : 4x4 matrix keypad scanner with scan-level debounce and a
//            valid/ready key event output. Define KEY_REPEAT_EN to build in
//            auto-repeat while a key is held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV     = 50_000,
    parameter int STABLE_SCANS = 10,
    parameter int REPEAT_SCANS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_drop
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_STB_W = $clog2(STABLE_SCANS + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_STB_W-1:0] c_STB_MAX   = c_STB_W'(STABLE_SCANS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [1:0]         r_col_idx;
    logic [1:0]         r_hits;
    logic [3:0]         r_acc_code;
    logic [4:0]         r_prev_result;
    logic [c_STB_W-1:0] r_stable_cnt;
    state_t             r_state;
    state_t             w_state_next;
    logic               r_evt;
    logic [3:0]         r_evt_code;

    logic               w_sample;
    logic               w_scan_end;
    logic [3:0]         w_low;
    logic [2:0]         w_col_hits;
    logic [1:0]         w_row_idx;
    logic [2:0]         w_total;
    logic [1:0]         w_hits_next;
    logic [3:0]         w_code_next;
    logic [4:0]         w_result;
    logic [c_STB_W-1:0] w_cnt_next;
    logic               w_stable;
    logic               w_enter;
    logic               w_repeat;

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_lut = 4'h1;
            4'h1: key_lut = 4'h2;
            4'h2: key_lut = 4'h3;
            4'h3: key_lut = 4'hA;
            4'h4: key_lut = 4'h4;
            4'h5: key_lut = 4'h5;
            4'h6: key_lut = 4'h6;
            4'h7: key_lut = 4'hB;
            4'h8: key_lut = 4'h7;
            4'h9: key_lut = 4'h8;
            4'hA: key_lut = 4'h9;
            4'hB: key_lut = 4'hC;
            4'hC: key_lut = 4'hE;
            4'hD: key_lut = 4'h0;
            4'hE: key_lut = 4'hF;
            default: key_lut = 4'hD;
        endcase
    endfunction

    assign col        = ~(4'b0001 << r_col_idx);
    assign key_held   = (r_state == ST_HELD);
    assign w_sample   = (r_div_cnt == c_DIV_LAST);
    assign w_scan_end = w_sample && (r_col_idx == 2'd3);
    assign w_low      = ~r_row_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
            r_div_cnt  <= '0;
            r_col_idx  <= '0;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_div_cnt <= '0;
                r_col_idx <= r_col_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Hits saturate at 2 so a multi-key scan collapses to "no key" below.
    always_comb begin
        w_col_hits = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
        w_row_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_low[i]) w_row_idx = 2'(i);
        end
        w_total     = {1'b0, r_hits} + w_col_hits;
        w_hits_next = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
        w_code_next = (w_col_hits == 3'd1) ? key_lut(w_row_idx, r_col_idx) : r_acc_code;
        w_result    = (w_hits_next == 2'd1) ? {1'b1, w_code_next} : 5'b0;
        if (w_result == r_prev_result) begin
            w_cnt_next = (r_stable_cnt == c_STB_MAX) ? r_stable_cnt : r_stable_cnt + 1'b1;
        end else begin
            w_cnt_next = c_STB_W'(1);
        end
        w_stable = (w_cnt_next == c_STB_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hits        <= '0;
            r_acc_code    <= '0;
            r_prev_result <= '0;
            r_stable_cnt  <= '0;
        end else if (w_scan_end) begin
            r_hits        <= '0;
            r_acc_code    <= '0;
            r_prev_result <= w_result;
            r_stable_cnt  <= w_cnt_next;
        end else if (w_sample) begin
            r_hits     <= w_hits_next;
            r_acc_code <= w_code_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // A different stable key while HELD is deliberately ignored until release.
    always_comb begin
        w_state_next = r_state;
        if (w_scan_end && w_stable) begin
            case (r_state)
                ST_IDLE: if (w_result[4])  w_state_next = ST_HELD;
                ST_HELD: if (!w_result[4]) w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_enter = (r_state == ST_IDLE) && (w_state_next == ST_HELD);

`ifdef KEY_REPEAT_EN
    localparam int c_REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_SCANS - 1);
    logic [c_REP_W-1:0] r_rep_cnt;

    assign w_repeat = w_scan_end && (r_state == ST_HELD) && (w_state_next == ST_HELD)
                      && (r_rep_cnt == c_REP_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_enter) begin
            r_rep_cnt <= '0;
        end else if (w_scan_end && (r_state == ST_HELD)) begin
            r_rep_cnt <= w_repeat ? '0 : r_rep_cnt + 1'b1;
        end
    end
`else
    // Repeat compiled out; the parameter stays referenced so both builds lint alike.
    assign w_repeat = (REPEAT_SCANS < 0);
`endif

    // r_evt_code only changes on entry to HELD, so repeats reuse the held code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt      <= 1'b0;
            r_evt_code <= '0;
        end else begin
            r_evt <= w_enter | w_repeat;
            if (w_enter) r_evt_code <= w_result[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_drop  <= 1'b0;
        end else if (r_evt) begin
            if (!key_valid || key_ready) begin
                key_code  <= r_evt_code;
                key_valid <= 1'b1;
            end else begin
                key_drop <= 1'b1;
            end
        end else if (key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
